// File: rtl/plasticity_pkg.sv
// Shared constants and signed saturate/clamp helpers for the synaptic plasticity datapath.
package plasticity_pkg;

   localparam int unsigned TRACE_WIDTH   = 18;
   localparam int unsigned WEIGHT_WIDTH  = 16;
   localparam int unsigned SUM_W         = WEIGHT_WIDTH + 2;
   localparam int unsigned A2_PLUS_SH    = 6;
   localparam int unsigned A2_MINUS_SH   = 4;
   localparam int unsigned U_SCALE_SHIFT = 9;

   localparam int TRACE_INC  = 256;
   localparam int MAX_WEIGHT = 1000;
   localparam int MIN_WEIGHT = 0;
   localparam int U_BASE     = 32;
   localparam int R_TARGET   = 256;
   localparam int ONE_U      = 1 << U_SCALE_SHIFT;

   localparam int unsigned R_SHIFT = $clog2(R_TARGET);

   // Wide signed working type; every intermediate here fits without overflow
   typedef logic signed [63:0] work_t;

   function automatic work_t clamp_s(input work_t x, input work_t lo, input work_t hi);
      work_t r;
      r = x;
      if (x < lo) r = lo;
      if (x > hi) r = hi;
      return r;
   endfunction

   // Saturate to the signed range of a w-bit two's complement value
   function automatic work_t sat_s(input work_t x, input int unsigned w);
      work_t hi;
      work_t lo;
      hi = (work_t'(1) <<< (w - 1)) - work_t'(1);
      lo = -(work_t'(1) <<< (w - 1));
      return clamp_s(x, lo, hi);
   endfunction

endpackage

// File: rtl/stp_efficacy.sv
// Combinational short-term plasticity path: facilitation of u, depletion of R, scaled efficacy.
module stp_efficacy
   import plasticity_pkg::*;
(
   input  logic                           pre_edge,
   input  logic signed [WEIGHT_WIDTH-1:0] weight_in,
   input  logic signed [TRACE_WIDTH-1:0]  u_in,
   input  logic signed [TRACE_WIDTH-1:0]  r_in,
   output logic signed [TRACE_WIDTH-1:0]  u_c,
   output logic signed [TRACE_WIDTH-1:0]  r_c,
   output logic signed [WEIGHT_WIDTH-1:0] efficacy_c
);

   work_t u_plus;
   work_t prod;
   work_t r_dep;

   always_comb begin
      u_plus = clamp_s(64'(u_in) + (((64'(ONE_U) - 64'(u_in)) * 64'(U_BASE)) >>> U_SCALE_SHIFT),
                       64'sd0, 64'(ONE_U));
      // Efficacy uses facilitated u and the pre-depletion resource
      prod   = 64'(weight_in) * u_plus * 64'(r_in);
      r_dep  = clamp_s(64'(r_in) - ((u_plus * 64'(r_in)) >>> U_SCALE_SHIFT),
                       64'sd0, 64'(R_TARGET));

      u_c        = u_in;
      r_c        = r_in;
      efficacy_c = '0;
      if (pre_edge) begin
         u_c        = TRACE_WIDTH'(u_plus);
         r_c        = TRACE_WIDTH'(r_dep);
         efficacy_c = WEIGHT_WIDTH'(sat_s(prod >>> (U_SCALE_SHIFT + R_SHIFT), WEIGHT_WIDTH));
      end
   end

endmodule

// File: rtl/plasticity_update_unit.sv
// Per-synapse STDP + STP update; one-cycle registered result for synapse-memory write-back.
module plasticity_update_unit
   import plasticity_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic                           enable_learning,
   input  logic                           pre_edge,
   input  logic                           post_edge,
   input  logic signed [WEIGHT_WIDTH-1:0] weight_in,
   input  logic signed [TRACE_WIDTH-1:0]  r1_in,
   input  logic signed [TRACE_WIDTH-1:0]  o1_in,
   input  logic signed [TRACE_WIDTH-1:0]  u_in,
   input  logic signed [TRACE_WIDTH-1:0]  R_in,
   output logic                           out_valid,
   output logic signed [WEIGHT_WIDTH-1:0] weight_out,
   output logic signed [TRACE_WIDTH-1:0]  r1_out,
   output logic signed [TRACE_WIDTH-1:0]  o1_out,
   output logic signed [TRACE_WIDTH-1:0]  u_out,
   output logic signed [TRACE_WIDTH-1:0]  R_out,
   output logic signed [WEIGHT_WIDTH-1:0] efficacy_out
);

   logic signed [SUM_W-1:0]        ltp;
   logic signed [SUM_W-1:0]        ltd;
   logic signed [SUM_W-1:0]        w_sum;
   logic signed [WEIGHT_WIDTH-1:0] weight_nxt;
   logic signed [TRACE_WIDTH-1:0]  r1_nxt;
   logic signed [TRACE_WIDTH-1:0]  o1_nxt;
   logic signed [TRACE_WIDTH-1:0]  u_nxt_c;
   logic signed [TRACE_WIDTH-1:0]  r_nxt_c;
   logic signed [WEIGHT_WIDTH-1:0] efficacy_nxt_c;

   stp_efficacy u_stp (
      .pre_edge   (pre_edge),
      .weight_in  (weight_in),
      .u_in       (u_in),
      .r_in       (R_in),
      .u_c        (u_nxt_c),
      .r_c        (r_nxt_c),
      .efficacy_c (efficacy_nxt_c)
   );

   // STDP: both terms read the pre-increment traces when edges coincide
   always_comb begin
      ltp        = '0;
      ltd        = '0;
      r1_nxt     = r1_in;
      o1_nxt     = o1_in;
      weight_nxt = weight_in;
      if (enable_learning && (pre_edge || post_edge)) begin
         if (post_edge) begin
            ltp    = SUM_W'(r1_in >>> A2_PLUS_SH);
            o1_nxt = TRACE_WIDTH'(sat_s(64'(o1_in) + 64'(TRACE_INC), TRACE_WIDTH));
         end
         if (pre_edge) begin
            ltd    = SUM_W'(o1_in >>> A2_MINUS_SH);
            r1_nxt = TRACE_WIDTH'(sat_s(64'(r1_in) + 64'(TRACE_INC), TRACE_WIDTH));
         end
      end
      w_sum = SUM_W'(weight_in) + ltp - ltd;
      if (enable_learning && (pre_edge || post_edge)) begin
         weight_nxt = WEIGHT_WIDTH'(clamp_s(64'(w_sum), 64'(MIN_WEIGHT), 64'(MAX_WEIGHT)));
      end
   end

   // Output register loads every cycle; out_valid qualifies the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         weight_out   <= '0;
         r1_out       <= '0;
         o1_out       <= '0;
         u_out        <= '0;
         R_out        <= '0;
         efficacy_out <= '0;
      end else begin
         out_valid    <= in_valid;
         weight_out   <= weight_nxt;
         r1_out       <= r1_nxt;
         o1_out       <= o1_nxt;
         u_out        <= u_nxt_c;
         R_out        <= r_nxt_c;
         efficacy_out <= efficacy_nxt_c;
      end
   end

endmodule

// File: tb/tb_plasticity_update_unit.sv
// Scoreboard bench for plasticity_update_unit: directed test-plan vectors plus randomized traffic.
module tb_plasticity_update_unit;

   typedef struct {
      bit en;
      bit pre;
      bit post;
      bit valid;
      int w;
      int r1;
      int o1;
      int u;
      int r;
   } stim_t;

   typedef struct {
      longint w;
      longint r1;
      longint o1;
      longint u;
      longint r;
      longint eff;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                enable_learning;
   logic                pre_edge;
   logic                post_edge;
   logic signed [15:0]  weight_in;
   logic signed [17:0]  r1_in;
   logic signed [17:0]  o1_in;
   logic signed [17:0]  u_in;
   logic signed [17:0]  R_in;
   logic                out_valid;
   logic signed [15:0]  weight_out;
   logic signed [17:0]  r1_out;
   logic signed [17:0]  o1_out;
   logic signed [17:0]  u_out;
   logic signed [17:0]  R_out;
   logic signed [15:0]  efficacy_out;

   int   n_vec  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b1;
   exp_t sb[$];

   always #5 clk = ~clk;

   plasticity_update_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .enable_learning (enable_learning),
      .pre_edge        (pre_edge),
      .post_edge       (post_edge),
      .weight_in       (weight_in),
      .r1_in           (r1_in),
      .o1_in           (o1_in),
      .u_in            (u_in),
      .R_in            (R_in),
      .out_valid       (out_valid),
      .weight_out      (weight_out),
      .r1_out          (r1_out),
      .o1_out          (o1_out),
      .u_out           (u_out),
      .R_out           (R_out),
      .efficacy_out    (efficacy_out)
   );

   function automatic longint fdiv(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint lim(input longint x, input longint lo, input longint hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   // Reference model straight from the plasticity rules, integer arithmetic
   function automatic exp_t model(input stim_t s);
      exp_t   e;
      longint ltp;
      longint ltd;
      longint up;
      ltp   = 0;
      ltd   = 0;
      e.w   = s.w;
      e.r1  = s.r1;
      e.o1  = s.o1;
      e.u   = s.u;
      e.r   = s.r;
      e.eff = 0;
      if (s.en && (s.pre || s.post)) begin
         if (s.post) begin
            ltp  = fdiv(s.r1, 64);
            e.o1 = lim(longint'(s.o1) + 256, -131072, 131071);
         end
         if (s.pre) begin
            ltd  = fdiv(s.o1, 16);
            e.r1 = lim(longint'(s.r1) + 256, -131072, 131071);
         end
         e.w = lim(longint'(s.w) + ltp - ltd, 0, 1000);
      end
      if (s.pre) begin
         up    = lim(longint'(s.u) + fdiv((512 - longint'(s.u)) * 32, 512), 0, 512);
         e.u   = up;
         e.eff = lim(fdiv(longint'(s.w) * up * longint'(s.r), 131072), -32768, 32767);
         e.r   = lim(longint'(s.r) - fdiv(up * longint'(s.r), 512), 0, 256);
      end
      return e;
   endfunction

   task automatic drive(input stim_t s, input bit push, input exp_t e);
      @(posedge clk);
      #1;
      in_valid        = s.valid;
      enable_learning = s.en;
      pre_edge        = s.pre;
      post_edge       = s.post;
      weight_in       = 16'(s.w);
      r1_in           = 18'(s.r1);
      o1_in           = 18'(s.o1);
      u_in            = 18'(s.u);
      R_in            = 18'(s.r);
      if (push && s.valid) sb.push_back(e);
   endtask

   task automatic chk(input string name, input longint got, input longint want);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic stim_t mk(input bit en, input bit pre, input bit post,
                                input int w, input int r1, input int o1, input int u, input int r);
      stim_t s;
      s.valid = 1'b1;
      s.en = en; s.pre = pre; s.post = post;
      s.w = w; s.r1 = r1; s.o1 = o1; s.u = u; s.r = r;
      return s;
   endfunction

   function automatic exp_t mkx(input longint w, input longint r1, input longint o1,
                                input longint u, input longint r, input longint eff);
      exp_t e;
      e.w = w; e.r1 = r1; e.o1 = o1; e.u = u; e.r = r; e.eff = eff;
      return e;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a valid result
   always @(negedge clk) begin
      if (mon_en && rst_n === 1'b1 && out_valid === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (longint'(weight_out) != e.w || longint'(r1_out) != e.r1 ||
                longint'(o1_out) != e.o1 || longint'(u_out) != e.u ||
                longint'(R_out) != e.r || longint'(efficacy_out) != e.eff) begin
               n_fail++;
               $display("FAIL result[%0d]: got w=%0d r1=%0d o1=%0d u=%0d R=%0d eff=%0d expected w=%0d r1=%0d o1=%0d u=%0d R=%0d eff=%0d",
                        n_vec, weight_out, r1_out, o1_out, u_out, R_out, efficacy_out,
                        e.w, e.r1, e.o1, e.u, e.r, e.eff);
            end
         end
      end
   end

   task automatic drain(input string name);
      stim_t idle;
      exp_t  none;
      int    budget;
      idle  = mk(0, 0, 0, 0, 0, 0, 0, 0);
      idle.valid = 1'b0;
      none  = mkx(0, 0, 0, 0, 0, 0);
      drive(idle, 1'b0, none);
      budget = 20;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      chk(name, longint'(sb.size()), 0);
      sb.delete();
   endtask

   initial begin
      stim_t s;
      exp_t  e;
      rst_n = 1'b0;
      in_valid = 1'b0; enable_learning = 1'b0; pre_edge = 1'b0; post_edge = 1'b0;
      weight_in = '0; r1_in = '0; o1_in = '0; u_in = '0; R_in = '0;
      #12;
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_data", longint'({weight_out, r1_out, o1_out, u_out, R_out, efficacy_out} != '0), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with hand-derived expectations
      drive(mk(1, 0, 1, 500, 640, 0, 0, 0), 1'b1, mkx(510, 640, 256, 0, 0, 0));
      drive(mk(1, 1, 0, 500, 0, 320, 0, 256), 1'b1, mkx(480, 256, 320, 32, 240, 31));
      drive(mk(1, 0, 1, 990, 131071, 131000, 0, 0), 1'b1, mkx(1000, 131071, 131071, 0, 0, 0));
      drive(mk(1, 1, 0, 100, 0, 20000, 0, 0), 1'b1, mkx(0, 256, 20000, 32, 0, 0));
      drive(mk(0, 1, 1, 700, 5000, 6000, 32, 256), 1'b1, mkx(700, 5000, 6000, 62, 225, 84));
      drive(mk(0, 1, 0, 1000, 0, 0, 32, 256), 1'b1, mkx(1000, 0, 0, 62, 225, 121));
      drive(mk(1, 0, 0, 300, 77, 88, 100, 200), 1'b1, mkx(300, 77, 88, 100, 200, 0));
      drive(mk(1, 1, 1, 500, 640, 320, 0, 0), 1'b1, mkx(490, 896, 576, 32, 0, 0));
      drain("directed_drain");

      // Randomized traffic with bubbles, checked against the model
      for (int i = 0; i < 400; i++) begin
         s.valid = ($urandom_range(0, 5) != 0);
         s.en    = ($urandom_range(0, 3) != 0);
         s.pre   = $urandom_range(0, 1) != 0;
         s.post  = $urandom_range(0, 1) != 0;
         s.w     = ($urandom_range(0, 7) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 1000));
         s.r1    = ($urandom_range(0, 3) == 0) ? int'($signed(18'($urandom))) : int'($urandom_range(0, 131071));
         s.o1    = ($urandom_range(0, 3) == 0) ? int'($signed(18'($urandom))) : int'($urandom_range(0, 131071));
         s.u     = int'($urandom_range(0, 600)) - 20;
         s.r     = int'($urandom_range(0, 320)) - 20;
         drive(s, 1'b1, model(s));
      end
      drain("random_drain");

      // Asynchronous reset in the middle of traffic
      mon_en = 1'b0;
      s = mk(1, 1, 1, 700, 5000, 6000, 32, 256);
      e = mkx(0, 0, 0, 0, 0, 0);
      drive(s, 1'b0, e);
      @(posedge clk);
      #2;
      chk("pre_reset_out_valid", longint'(out_valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_out_valid", longint'(out_valid), 0);
      chk("async_reset_data", longint'({weight_out, r1_out, o1_out, u_out, R_out, efficacy_out} != '0), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("held_reset_data", longint'({out_valid, weight_out, r1_out, o1_out, u_out, R_out, efficacy_out} != '0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      s.valid = 1'b0;
      drive(s, 1'b0, e);
      @(posedge clk);
      #1;
      chk("post_release_idle", longint'(out_valid), 0);
      mon_en = 1'b1;
      s = mk(0, 1, 0, 1000, 0, 0, 32, 256);
      drive(s, 1'b1, model(s));
      drain("post_reset_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
